aes_decrypt_iter: RTL and testbench
===================================

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 Parameter KEY_BITS, default 128, key size in bits; legal values 128/192/256; NR = 10/12/14 respectively.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 s_valid  input  1  ciphertext block offered.
REQ-005 s_ready  output  1  block accepted on the edge where s_valid&&s_ready.
REQ-006 s_data  input  128  ciphertext block.
REQ-007 rk_idx  output  4  index of round key requested this cycle.
REQ-008 rk  input  128  round key for rk_idx, combinationally valid in the same cycle (external key store).
REQ-009 m_valid  output  1  plaintext valid.
REQ-010 m_ready  input  1  downstream accepts on the edge where m_valid&&m_ready.
REQ-011 m_data  output  128  plaintext block.
REQ-012 busy  output  1  high in ROUND or FINAL.

Function
REQ-013 FSM states: IDLE, ROUND, FINAL, DONE; 4-bit down-counter rnd.
REQ-014 s_ready = (state==IDLE) || (state==DONE && m_ready).
REQ-015 In IDLE/DONE, rk_idx = NR; on accept: state_reg <= s_data ^ rk, rnd <= NR-1, go to ROUND.
REQ-016 ROUND: rk_idx = rnd; state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk)); rnd decrements; at rnd==1 go to FINAL.
REQ-017 FINAL: rk_idx = 0; m_data <= AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk), no InvMixColumns; m_valid <= 1; go to DONE.
REQ-018 Latency: m_valid rises NR+1 edges after the accept edge (11 for KEY_BITS=128); throughput one block per NR+1 cycles with m_ready held high.
REQ-019 DONE: m_data and m_valid hold stable while m_ready low; on m_ready with no s_valid, m_valid <= 0 and go to IDLE.
REQ-020 DONE with m_ready and s_valid same cycle: output retired and new block accepted on the same edge; m_valid falls next cycle.
REQ-021 s_valid ignored in ROUND/FINAL; s_data need not be held after accept.

Reset
REQ-022 rst_n low at an edge: state IDLE, rnd 0, m_valid 0, m_data 0, state_reg 0, rk_idx NR, busy 0, s_ready 1 from the following cycle.
REQ-023 Reset mid-operation discards the block in flight; no m_valid for it ever appears.

Configuration
REQ-024 Macro AES_DEC_ABORT_EN defined: extra port abort input 1; abort high at an edge in any state forces IDLE, m_valid 0, m_data 0; abort overrides a simultaneous accept or output handshake.
REQ-025 Macro AES_DEC_ABORT_EN undefined: no abort port, behaviour per REQ-013..023 only.

Structure
REQ-026 Shared package aes_pkg holds: NR function of KEY_BITS, FSM state enum, inverse S-box table, GF(2^8) xtime/multiply functions, 128-bit block typedef.
REQ-027 One sub-module aes_dec_round_core: combinational InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns with input last_round bypassing InvMixColumns; instantiated once.

Verification
REQ-028 KEY_BITS=128, key 000102...0f schedule, s_data 69c4e0d86a7b0430d8cdb78070b4c55a -> m_data 00112233445566778899aabbccddeeff, m_valid exactly 11 cycles after accept.
REQ-029 KEY_BITS=192, key 000102...17, s_data dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 13 cycles; KEY_BITS=256, key 000102...1f, s_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 15 cycles.
REQ-030 m_ready held low 20 cycles after m_valid -> m_data stable, s_ready 0, then one handshake; back-to-back two blocks with s_valid and m_ready high -> second accepted on first's retire edge, outputs 12 cycles apart (KEY_BITS=128).
REQ-031 rst_n low at cycle 5 of a block -> m_valid never rises for it; next block decrypts correctly.
REQ-032 AES_DEC_ABORT_EN defined: abort at rnd==4 simultaneous with s_valid -> IDLE, no accept, m_valid 0; abort undefined build elaborates without the port.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES decryption types, round-count helper, inverse S-box and GF(2^8) arithmetic
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    function automatic logic [3:0] nr_of(input int key_bits);
        return (key_bits == 256) ? 4'd14 : (key_bits == 192) ? 4'd12 : 4'd10;
    endfunction

    // Byte 0 of the table sits in the most significant position.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Only 4-bit multipliers are needed by InvMixColumns (09, 0b, 0d, 0e).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_dec_round_core.sv
// rtl/aes_dec_round_core.sv - combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_dec_round_core
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t round_key,
    input  logic   last_round,
    output block_t state_out
);

    logic [7:0] in_b  [16];
    logic [7:0] sub_b [16];
    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    // Bytes are column-major: index r + 4*c, byte 0 is the block MSB.
    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            in_b[i] = state_in[127 - 8 * i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_b[r + 4 * c] = inv_sbox(in_b[r + 4 * ((c - r + 4) % 4)]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ark_b[i] = sub_b[i] ^ round_key[127 - 8 * i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mix_b[4 * c + r] = gmul(ark_b[4 * c + r], 4'he)
                                 ^ gmul(ark_b[4 * c + (r + 1) % 4], 4'hb)
                                 ^ gmul(ark_b[4 * c + (r + 2) % 4], 4'hd)
                                 ^ gmul(ark_b[4 * c + (r + 3) % 4], 4'h9);
            end
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8 * i -: 8] = last_round ? ark_b[i] : mix_b[i];
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES decryptor, one inverse round per cycle, round keys from an external store
// Optional abort input is enabled by defining AES_DEC_ABORT_EN.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         busy
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [3:0] NR = nr_of(KEY_BITS);

    state_t state;
    state_t state_nxt;
    logic [3:0] rnd;
    block_t state_reg;
    block_t core_out;
    logic accept;
    logic clear;
    logic last_round;

`ifdef AES_DEC_ABORT_EN
    assign clear = !rst_n || abort;
`else
    assign clear = !rst_n;
`endif

    assign last_round = (state == ST_FINAL);

    aes_dec_round_core u_core (
        .state_in  (state_reg),
        .round_key (rk),
        .last_round(last_round),
        .state_out (core_out)
    );

    always_comb begin
        s_ready   = (state == ST_IDLE) || (state == ST_DONE && m_ready);
        accept    = s_valid && s_ready;
        busy      = (state == ST_ROUND) || (state == ST_FINAL);
        rk_idx    = NR;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                rk_idx = rnd;
                if (rnd == 4'd1) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                rk_idx    = 4'd0;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (accept) state_nxt = ST_ROUND;
                else if (m_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In DONE an accept implies m_ready, so retire and reload share the edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_IDLE;
            rnd       <= '0;
            state_reg <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                state_reg <= s_data ^ rk;
                rnd       <= NR - 4'd1;
            end
            if (state == ST_ROUND) begin
                state_reg <= core_out;
                rnd       <= rnd - 4'd1;
            end
            if (state == ST_FINAL) begin
                m_data  <= core_out;
                m_valid <= 1'b1;
            end
            if (state == ST_DONE && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench: three key sizes, forward-cipher reference model, random blocks
module tb_aes_decrypt_iter;

    localparam int NI = 3;
    localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_KV = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         s_valid [NI];
    logic [127:0] s_data  [NI];
    logic         m_ready [NI];
    wire          s_ready [NI];
    wire  [3:0]   rk_idx  [NI];
    wire  [127:0] rk      [NI];
    wire          m_valid [NI];
    wire  [127:0] m_data  [NI];
    wire          busy    [NI];
`ifdef AES_DEC_ABORT_EN
    logic         abort   [NI];
`endif

    logic [127:0] rks [NI][16];
    logic [7:0]   sbox [256];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign rk[g] = rks[g][rk_idx[g]];

        aes_decrypt_iter #(.KEY_BITS(128 + 64 * g)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .s_valid(s_valid[g]),
            .s_ready(s_ready[g]),
            .s_data (s_data[g]),
            .rk_idx (rk_idx[g]),
            .rk     (rk[g]),
            .m_valid(m_valid[g]),
            .m_ready(m_ready[g]),
            .m_data (m_data[g]),
            .busy   (busy[g])
`ifdef AES_DEC_ABORT_EN
            ,
            .abort  (abort[g])
`endif
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Instance k uses a key of 4+2k words, taken from the top of the 256-bit value.
    task automatic expand_key(input int k, input logic [255:0] key);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk   = 4 + 2 * k;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rks[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Forward cipher: the bench derives ciphertext from random plaintext and expects the plaintext back.
    function automatic logic [127:0] encrypt(input int k, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        int nr;
        nr = 10 + 2 * k;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rks[k][0][127 - 8 * i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4 * c] = sbox[s[r + 4 * ((c + r) % 4)]];
            if (rd < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4 * c + r] = gf_mul(t[4 * c + r], 8'h02) ^ gf_mul(t[4 * c + (r + 1) % 4], 8'h03)
                                     ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[k][rd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Latency counts edges inclusively: the accept edge through the edge that raises m_valid.
    task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] exp,
                             input int stall, input string tag);
        int acc_edge, rise_edge, n;
        logic [127:0] held;
        logic stable;
        @(negedge clk);
        s_valid[k] = 1'b1;
        s_data[k]  = ct;
        m_ready[k] = 1'b0;
        n = 0;
        while (!s_ready[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        acc_edge   = cyc;
        s_valid[k] = 1'b0;
        s_data[k]  = rand128();
        n = 0;
        while (!m_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        rise_edge = cyc;
        check_eq({tag, " valid"}, 128'(m_valid[k]), 128'(1));
        check_eq({tag, " data"}, m_data[k], exp);
        check_eq({tag, " latency"}, 128'(rise_edge - acc_edge + 1), 128'(11 + 2 * k));
        held   = m_data[k];
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (m_data[k] !== held || !m_valid[k] || s_ready[k]) stable = 1'b0;
        end
        if (stall > 0) check_eq({tag, " stall hold"}, 128'(stable), 128'(1));
        m_ready[k] = 1'b1;
        @(negedge clk);
        m_ready[k] = 1'b0;
        check_eq({tag, " retire"}, 128'({m_valid[k], busy[k], s_ready[k]}), 128'(3'b001));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt, pt2;
        int n, t1, t2, k;
        logic seen;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            m_ready[i] = 1'b0;
`ifdef AES_DEC_ABORT_EN
            abort[i]   = 1'b0;
`endif
        end
        build_sbox();
        for (int i = 0; i < NI; i++) expand_key(i, KEY_SEQ);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("reset s_ready", 128'(s_ready[0]), 128'(1));
        check_eq("reset m_valid", 128'(m_valid[0]), 128'(0));
        check_eq("reset m_data", m_data[0], 128'(0));
        check_eq("reset busy", 128'(busy[0]), 128'(0));
        for (int i = 0; i < NI; i++) check_eq("reset rk_idx", 128'(rk_idx[i]), 128'(10 + 2 * i));

        run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_KV, 0, "kv128");
        run_block(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_KV, 0, "kv192");
        run_block(2, 128'h8ea2b7ca516745bfeafc49904b496089, PT_KV, 0, "kv256");

        pt = rand128();
        run_block(0, encrypt(0, pt), pt, 20, "stall20");

        // Back-to-back: second block offered while the first is still in flight.
        pt  = rand128();
        pt2 = rand128();
        @(negedge clk);
        m_ready[0] = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = encrypt(0, pt);
        @(negedge clk);
        s_data[0] = encrypt(0, pt2);
        n = 0;
        while (!m_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check_eq("b2b first data", m_data[0], pt);
        check_eq("b2b s_ready in done", 128'(s_ready[0]), 128'(1));
        @(negedge clk);
        s_valid[0] = 1'b0;
        check_eq("b2b retire+accept", 128'({m_valid[0], busy[0]}), 128'(2'b01));
        n = 0;
        while (!m_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        check_eq("b2b second data", m_data[0], pt2);
        check_eq("b2b spacing", 128'(t2 - t1 + 1), 128'(12));
        @(negedge clk);
        m_ready[0] = 1'b0;

        // Reset five cycles into a block: its result must never appear.
        pt = rand128();
        @(negedge clk);
        m_ready[0] = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = encrypt(0, pt);
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midreset idle", 128'({busy[0], s_ready[0], m_valid[0]}), 128'(3'b010));
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid[0]) seen = 1'b1;
        end
        check_eq("midreset no output", 128'(seen), 128'(0));
        m_ready[0] = 1'b0;
        pt = rand128();
        run_block(0, encrypt(0, pt), pt, 1, "post_reset");

        for (int i = 0; i < NI; i++) expand_key(i, {rand128(), rand128()});
        for (int it = 0; it < 12; it++) begin
            k  = $urandom_range(0, 2);
            pt = rand128();
            run_block(k, encrypt(k, pt), pt, $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef AES_DEC_ABORT_EN
        pt = rand128();
        @(negedge clk);
        s_valid[0] = 1'b1;
        s_data[0]  = encrypt(0, pt);
        @(negedge clk);
        s_valid[0] = 1'b0;
        n = 0;
        while (rk_idx[0] != 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        abort[0]   = 1'b1;
        s_valid[0] = 1'b1;
        @(negedge clk);
        abort[0]   = 1'b0;
        s_valid[0] = 1'b0;
        check_eq("abort idle", 128'({busy[0], m_valid[0], s_ready[0]}), 128'(3'b001));
        check_eq("abort m_data", m_data[0], 128'(0));
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid[0]) seen = 1'b1;
        end
        check_eq("abort no output", 128'(seen), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
